// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode map, FSM states, iterative engine modes.
package alu_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned OP_LAST = 9;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_LSR = 4'd5,
    OP_LSL = 4'd6,
    OP_MOD = 4'd7,
    OP_MUL = 4'd8,
    OP_DIV = 4'd9
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_t;

  typedef enum logic {
    ITER_MUL = 1'b0,
    ITER_DIV = 1'b1
  } iter_mode_t;

  // True when the op must go through the N-step engine (div/mod by zero short-circuits).
  function automatic logic op_is_iter(input logic [OP_W-1:0] op, input logic b_zero);
    return (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && !b_zero);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative N-step engine shared by multiply (shift-add) and divide/modulo (restoring).
// Ports: start loads a/b/mode; done_c is high during the last step; hi_c/lo_c are the
// values that step produces (mul: product high/low, div: remainder/quotient).
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  iter_mode_t   mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done_c,
  output logic [N-1:0] hi_c,
  output logic [N-1:0] lo_c
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N-1:0]  b_q, b_d;
  iter_mode_t    mode_q, mode_d;

  logic [N:0]    mul_sum;
  logic [N:0]    div_shift;
  logic [N:0]    div_diff;

  // One iteration. Mul: {hi,lo} holds partial product / remaining multiplier bits.
  // Div: hi is the partial remainder, lo shifts dividend out and quotient bits in;
  // div_diff[N] is the borrow, i.e. the trial subtraction failed.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, b_q & {N{lo_q[0]}}};
    div_shift = {hi_q, lo_q[N-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (mode_q == ITER_MUL) begin
      hi_c = mul_sum[N:1];
      lo_c = {mul_sum[0], lo_q[N-1:1]};
    end else begin
      hi_c = div_diff[N] ? div_shift[N-1:0] : div_diff[N-1:0];
      lo_c = {lo_q[N-2:0], ~div_diff[N]};
    end
  end

  assign done_c = (cnt_q == CW'(1));

  // Load on start, otherwise step while the counter is running.
  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    mode_d = mode_q;
    if (start) begin
      cnt_d  = CW'(N);
      hi_d   = '0;
      lo_d   = a;
      b_d    = b;
      mode_d = mode;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      hi_d  = hi_c;
      lo_d  = lo_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      mode_q <= ITER_MUL;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
      mode_q <= mode_d;
    end
  end

endmodule

// File: rtl/alu_seq_n_bits.sv
// Sequential N-bit ALU with valid/ready handshakes, registered result and flags.
// Ports: in_valid/in_ready + a, b, op accept an operation; out_valid/out_ready
// hand off result with flags v, c, n, z, dz (divide by zero) and err (illegal op).
// Single-cycle ops answer one cycle after accept; mul/div/mod take N more cycles.
module alu_seq_n_bits
  import alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         v,
  output logic         c,
  output logic         n,
  output logic         z,
  output logic         dz,
  output logic         err
);

  localparam int unsigned W1 = N + 1;

  alu_state_t   state_q, state_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] result_q, result_d;
  logic         v_q, v_d, c_q, c_d, n_q, n_d, z_q, z_d, dz_q, dz_d, err_q, err_d;
  logic [3:0]   op_q, op_d;

  logic         accept_c;
  logic         start_c;
  iter_mode_t   mode_c;
  logic         done_c;
  logic [N-1:0] hi_c, lo_c;

  logic [N:0]   add_w, sub_w;
  logic [N-1:0] sc_res;
  logic         sc_v, sc_c, sc_dz, sc_err;
  logic [N-1:0] it_res;
  logic         it_v;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept_c = in_valid && in_ready;
  assign mode_c   = (op == OP_MUL) ? ITER_MUL : ITER_DIV;

  alu_iter_unit #(.N(N)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_c),
    .mode   (mode_c),
    .a      (a),
    .b      (b),
    .done_c (done_c),
    .hi_c   (hi_c),
    .lo_c   (lo_c)
  );

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} + {1'b0, ~b} + W1'(1);

  // Single-cycle datapath; div/mod only land here when b is zero.
  always_comb begin
    sc_res = '0;
    sc_v   = 1'b0;
    sc_c   = 1'b0;
    sc_dz  = 1'b0;
    sc_err = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = add_w[N-1:0];
        sc_c   = add_w[N];
        sc_v   = (a[N-1] == b[N-1]) && (add_w[N-1] != a[N-1]);
      end
      OP_SUB: begin
        sc_res = sub_w[N-1:0];
        sc_c   = sub_w[N];
        sc_v   = (a[N-1] != b[N-1]) && (sub_w[N-1] != a[N-1]);
      end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      // Shift amounts >= N shift everything out, giving 0.
      OP_LSR: sc_res = a >> b;
      OP_LSL: sc_res = a << b;
      OP_MOD, OP_DIV: sc_dz = 1'b1;
      OP_MUL: sc_res = '0;
      default: sc_err = 1'b1;
    endcase
  end

  // Result selection for the engine's final step.
  always_comb begin
    it_res = (op_q == OP_MOD) ? hi_c : lo_c;
    it_v   = (op_q == OP_MUL) && (hi_c != '0);
  end

  // Handshake FSM and output register update.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    v_d         = v_q;
    c_d         = c_q;
    n_d         = n_q;
    z_d         = z_q;
    dz_d        = dz_q;
    err_d       = err_q;
    op_d        = op_q;
    start_c     = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (op_is_iter(op, b == '0)) begin
            state_d = BUSY;
            start_c = 1'b1;
            op_d    = op;
          end else begin
            out_valid_d = 1'b1;
            result_d    = sc_res;
            v_d         = sc_v;
            c_d         = sc_c;
            n_d         = sc_res[N-1];
            z_d         = (sc_res == '0);
            dz_d        = sc_dz;
            err_d       = sc_err;
          end
        end
      end
      BUSY: begin
        // Output slot is guaranteed free: accept required it.
        if (done_c) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          result_d    = it_res;
          v_d         = it_v;
          c_d         = 1'b0;
          n_d         = it_res[N-1];
          z_d         = (it_res == '0);
          dz_d        = 1'b0;
          err_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      v_q         <= 1'b0;
      c_q         <= 1'b0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      dz_q        <= 1'b0;
      err_q       <= 1'b0;
      op_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      v_q         <= v_d;
      c_q         <= c_d;
      n_q         <= n_d;
      z_q         <= z_d;
      dz_q        <= dz_d;
      err_q       <= err_d;
      op_q        <= op_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign v         = v_q;
  assign c         = c_q;
  assign n         = n_q;
  assign z         = z_q;
  assign dz        = dz_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_n_bits.sv
module tb_alu_seq_n_bits;

  localparam int N = 4;
  localparam int W = 1 << N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] result;
  logic         v, c, n, z, dz, err;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  // Transaction-level reference state
  int m_left = 0;
  bit mv = 1'b0;
  int m_res = 0;
  bit m_v = 1'b0, m_c = 1'b0, m_dz = 1'b0, m_err = 1'b0;

  alu_seq_n_bits #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .v         (v),
    .c         (c),
    .n         (n),
    .z         (z),
    .dz        (dz),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= W / 2) ? x - W : x;
  endfunction

  // Arithmetic reference from the opcode definitions.
  function automatic void model_calc(input int o, input int x, input int y,
                                     output int r, output bit fv, output bit fc,
                                     output bit fdz, output bit ferr, output bit multi);
    int s;
    r = 0; fv = 0; fc = 0; fdz = 0; ferr = 0; multi = 0;
    case (o)
      0: begin s = x + y; r = s % W; fc = (s >= W);
               s = sgn(x) + sgn(y); fv = (s > W/2 - 1) || (s < -W/2); end
      1: begin s = x + (W - 1 - y) + 1; r = s % W; fc = (s >= W);
               s = sgn(x) - sgn(y); fv = (s > W/2 - 1) || (s < -W/2); end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = (y >= N) ? 0 : (x >> y);
      6: r = (y >= N) ? 0 : ((x << y) % W);
      7: if (y == 0) fdz = 1; else begin r = x % y; multi = 1; end
      8: begin s = x * y; r = s % W; fv = (s >= W); multi = 1; end
      9: if (y == 0) fdz = 1; else begin r = x / y; multi = 1; end
      default: ferr = 1;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int r; bit fv, fc, fdz, ferr, mu, rdy;
    if (!rst_n) begin
      mv = 0;
      m_left = 0;
    end else begin
      rdy = (m_left == 0) && (!mv || out_ready);
      if (mv && out_ready) mv = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) mv = 1;
      end else if (in_valid && rdy) begin
        model_calc(int'(op), int'(a), int'(b), r, fv, fc, fdz, ferr, mu);
        m_res = r; m_v = fv; m_c = fc; m_dz = fdz; m_err = ferr;
        if (mu) m_left = N;
        else mv = 1;
      end
    end
  end

  // Per-cycle comparison against the reference.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("mon in_ready", int'(in_ready), int'((m_left == 0) && (!mv || out_ready)));
      check("mon out_valid", int'(out_valid), int'(mv));
      if (mv && out_valid) begin
        check("mon result", int'(result), m_res);
        check("mon flags", int'({v, c, n, z, dz, err}),
              int'({m_v, m_c, m_res >= W / 2, m_res == 0, m_dz, m_err}));
      end
    end
  end

  // Issue one op with out_ready=1 and check latency, result and flags {v,c,n,z,dz,err}.
  task automatic run_op(input string name, input logic [3:0] o, input logic [N-1:0] x,
                        input logic [N-1:0] y, input logic [N-1:0] er, input logic [5:0] ef,
                        input int el);
    bit ok;
    int lat;
    @(posedge clk); #2;
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    check({name, " accept"}, int'(ok), 1);
    @(posedge clk); #2;
    in_valid = 1'b0; a = N'($urandom); b = N'($urandom); op = 4'($urandom);
    lat = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
      if (el > 1) check({name, " busy in_ready"}, int'(in_ready), 0);
    end
    check({name, " latency"}, lat, el);
    check({name, " result"}, int'(result), int'(er));
    check({name, " flags"}, int'({v, c, n, z, dz, err}), int'(ef));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst out_valid", int'(out_valid), 0);
    check("rst result", int'(result), 0);
    check("rst flags", int'({v, c, n, z, dz, err}), 0);
    check("rst in_ready", int'(in_ready), 1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    mon_en = 1'b1;

    //      name        op     a      b      result flags{v,c,n,z,dz,err} latency
    run_op("add 7+9",  4'd0,  4'd7,  4'd9,  4'h0, 6'b010100, 1);
    run_op("add 7+1",  4'd0,  4'd7,  4'd1,  4'h8, 6'b101000, 1);
    run_op("sub 3-5",  4'd1,  4'd3,  4'd5,  4'hE, 6'b001000, 1);
    run_op("sub 8-1",  4'd1,  4'd8,  4'd1,  4'h7, 6'b110000, 1);
    run_op("and",      4'd2,  4'hC,  4'hA,  4'h8, 6'b001000, 1);
    run_op("or",       4'd3,  4'h5,  4'hA,  4'hF, 6'b001000, 1);
    run_op("xor",      4'd4,  4'h9,  4'h9,  4'h0, 6'b000100, 1);
    run_op("lsr 12>>2",4'd5,  4'hC,  4'd2,  4'h3, 6'b000000, 1);
    run_op("lsl 3<<2", 4'd6,  4'h3,  4'd2,  4'hC, 6'b001000, 1);
    run_op("lsl 3<<5", 4'd6,  4'h3,  4'd5,  4'h0, 6'b000100, 1);
    run_op("mul 6*3",  4'd8,  4'd6,  4'd3,  4'h2, 6'b100000, 5);
    run_op("mul 15*15",4'd8,  4'hF,  4'hF,  4'h1, 6'b100000, 5);
    run_op("div 13/4", 4'd9,  4'd13, 4'd4,  4'h3, 6'b000000, 5);
    run_op("mod 13%4", 4'd7,  4'd13, 4'd4,  4'h1, 6'b000000, 5);
    run_op("div 15/1", 4'd9,  4'hF,  4'd1,  4'hF, 6'b001000, 5);
    run_op("mod 7%9",  4'd7,  4'd7,  4'd9,  4'h7, 6'b000000, 5);
    run_op("div 5/0",  4'd9,  4'd5,  4'd0,  4'h0, 6'b000110, 1);
    run_op("mod 5%0",  4'd7,  4'd5,  4'd0,  4'h0, 6'b000110, 1);
    run_op("op 12",    4'd12, 4'd3,  4'd4,  4'h0, 6'b000101, 1);

    // Backpressure: result held, then a new op issues the same edge it is taken.
    @(posedge clk); #2;
    out_ready = 1'b0; op = 4'd0; a = 4'd2; b = 4'd3; in_valid = 1'b1;
    @(posedge clk); #2;
    a = 4'd1; b = 4'd1;
    repeat (3) begin
      @(negedge clk);
      check("hold out_valid", int'(out_valid), 1);
      check("hold result", int'(result), 5);
      check("hold in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(negedge clk);
    check("b2b in_ready", int'(in_ready), 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b out_valid", int'(out_valid), 1);
    check("b2b result", int'(result), 2);

    // Reset in the middle of a multiply aborts it.
    @(posedge clk); #2;
    op = 4'd8; a = 4'd5; b = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("mid-rst accept", int'(in_ready), 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid-rst out_valid", int'(out_valid), 0);
    check("mid-rst in_ready", int'(in_ready), 1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post-rst out_valid", int'(out_valid), 0);
      check("post-rst in_ready", int'(in_ready), 1);
    end
    run_op("mul 5*3", 4'd8, 4'd5, 4'd3, 4'hF, 6'b001000, 5);
    run_op("add 1+2", 4'd0, 4'd1, 4'd2, 4'h3, 6'b000000, 1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_n_bits.md
Name: alu_seq_n_bits

Overview:
Parametrised sequential ALU, the successor to the 4-bit combinational lab ALU. It keeps the same 10-operation opcode map and adds operand/result valid-ready handshakes, a registered result with flags, and iterative N-cycle multiply and divide/modulo. It also reports illegal opcodes and divide-by-zero. It sits between the operand source (switch/button front end or a controller) and the display/result consumer.

Parameters:
N, 8, operand and result width in bits (N >= 2)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and op presented
in_ready  output  1  block can accept an operation this cycle
a  input  N  operand A, unsigned, or two's complement for add/sub flags
b  input  N  operand B, or shift amount
op  input  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 lsr, 6 lsl, 7 mod, 8 mul, 9 div, 10-15 illegal
out_valid  output  1  result and flags valid
out_ready  input  1  consumer takes the result this cycle
result  output  N  registered result
v, c, n, z  output  1 each  registered flags
dz  output  1  divide/mod by zero occurred
err  output  1  illegal opcode

Behaviour:
- Reset: async on rst_n low. state=IDLE; out_valid, result, v, c, n, z, dz, err all 0; iteration registers cleared.
- Accept: an operation is accepted on an edge where in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready). Issue is back-to-back when the consumer is ready.
- Output hold: while out_valid && !out_ready, result and flags stay stable. Accepting a new op while out_ready=1 replaces the output.
- Single-cycle ops (0-6, illegal, div/mod with b==0):
  - Result and flags are registered at the accept edge; out_valid is high the next cycle.
- Multi-cycle ops (7, 8, 9 with b!=0):
  - Operands are captured at the accept edge; state goes to BUSY with counter=N.
  - One iteration per edge for N edges. The final edge writes the output and returns to IDLE.
  - out_valid rises exactly N cycles later than it would for a single-cycle op.
  - in_ready=0 throughout BUSY. A pending out_valid cannot block the final write, because in_ready already required the output slot to be free.
- FSM: IDLE -> BUSY (accepted mul/div/mod with b!=0); BUSY -> BUSY (counter>1); BUSY -> IDLE (counter==1, output written).
- Arithmetic, all results truncated to N bits:
  - add: a+b, c=carry out, v=signed overflow.
  - sub: a+~b+1, c=carry out (1 = no borrow), v=signed overflow.
  - lsr, lsl: shift by b; if b >= N, result=0.
  - mul: unsigned shift-add over N steps; result = low N bits of product; v=1 iff the high N bits are nonzero; c=0.
  - div, mod: unsigned restoring division over N steps; div gives the quotient, mod gives the remainder.
  - b==0 for div/mod: result=0, dz=1, single cycle.
  - illegal opcode: result=0, err=1.
- Flags:
  - z = (result==0) and n = result[N-1] for every op.
  - c and v are 0 for every op except as defined above.
  - dz and err are 0 unless set by the current result.
- Reset mid-operation aborts the operation: BUSY -> IDLE, no output produced.
- Inputs are ignored when in_ready=0. Operands are sampled only at the accept edge; changing a, b or op during BUSY has no effect.

Decomposition:
- Package alu_pkg: opcode enum alu_op_t (OP_ADD..OP_DIV), state enum alu_state_t (IDLE, BUSY), localparam OP_LAST=9.
- Sub-module alu_iter_unit: shared iterative engine with start, mode (mul/div), a, b, done, hi/lo outputs. The top level holds the handshake, the single-cycle datapath and the flag registers.

Test Plan:
- N=4, add a=7, b=9 -> result 0, c=1, z=1, v=0, n=0; out_valid one cycle after accept.
- N=4, add a=7, b=1 -> result 8, v=1, n=1, c=0. Sub a=3, b=5 -> result 0xE, n=1, c=0, v=0.
- N=4, mul a=6, b=3 -> result 2, v=1; out_valid exactly 4 cycles later than a single-cycle op; in_ready=0 during BUSY.
- N=4, div 13/4 -> 3; mod 13%4 -> 1. Div 5/0 -> result 0, dz=1, z=1, single-cycle latency. Op 12 -> err=1, result 0.
- Backpressure: out_ready=0 after a result -> result and flags held and in_ready=0. Raise out_ready together with a new in_valid -> next result issued back-to-back.
- rst_n pulsed low mid-mul (counter=2) -> out_valid stays 0, state IDLE, in_ready=1 after release; the next op executes correctly.
